// File: rtl/morse_playback_scheduler.sv
// Morse playback scheduler: snapshots up to eight character entries and drives the
// buzzer with unit-timed dots, dashes, symbol gaps, character gaps and word spaces.
module morse_playback_scheduler #(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [3:0]  char_count,
  input  logic [63:0] char_buf,
  input  logic [1:0]  speed_sel,
  output logic        beep,
  output logic        busy,
  output logic        done,
  output logic [2:0]  cur_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TONE, S_SYM_GAP, S_SPACE, S_CHAR_GAP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] buf_q;
  logic [3:0]  n_q;
  logic [31:0] unit_q;
  logic [2:0]  index_q;
  logic [2:0]  rem_q;
  logic [4:0]  sym_q;
  logic [31:0] cnt_q;

  logic [3:0]  n_clamp;
  logic [31:0] unit_calc;
  logic [31:0] unit3;
  logic [31:0] unit4;
  logic [7:0]  entry;
  logic [2:0]  entry_len;
  logic        last_entry;
  logic        cnt_zero;

  assign n_clamp    = (char_count > 4'd8) ? 4'd8 : char_count;
  assign unit_calc  = UNIT_CYCLES * ({30'd0, speed_sel} + 32'd1);
  assign unit3      = unit_q + (unit_q << 1);
  assign unit4      = unit_q << 2;
  assign entry      = buf_q[{index_q, 3'b000} +: 8];
  assign entry_len  = (entry[7:5] > 3'd5) ? 3'd5 : entry[7:5];
  assign last_entry = ({1'b0, index_q} == (n_q - 4'd1));
  assign cnt_zero   = (cnt_q == 32'd0);

  // start is a level request sampled every cycle, honoured only in IDLE with en high;
  // there is no ready/acknowledge, busy simply masks further requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (en && start) state_d = (n_clamp == 4'd0) ? S_DONE : S_LOAD;
      S_LOAD:     state_d = (entry_len == 3'd0) ? S_SPACE : S_TONE;
      S_TONE: begin
        if (cnt_zero) begin
          if (rem_q != 3'd0)    state_d = S_SYM_GAP;
          else if (!last_entry) state_d = S_CHAR_GAP;
          else                  state_d = S_DONE;
        end
      end
      S_SYM_GAP:  if (cnt_zero) state_d = S_TONE;
      S_SPACE:    if (cnt_zero) state_d = last_entry ? S_DONE : S_CHAR_GAP;
      S_CHAR_GAP: if (cnt_zero) state_d = S_LOAD;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= 64'd0;
      n_q     <= 4'd0;
      unit_q  <= 32'd0;
      index_q <= 3'd0;
      rem_q   <= 3'd0;
      sym_q   <= 5'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (en && start && (n_clamp != 4'd0)) begin
            buf_q   <= char_buf;
            n_q     <= n_clamp;
            unit_q  <= unit_calc;
            index_q <= 3'd0;
          end
        end
        S_LOAD: begin
          sym_q <= entry[4:0];
          rem_q <= entry_len - 3'd1;
          if (entry_len == 3'd0) cnt_q <= unit4 - 32'd1;
          else                   cnt_q <= entry[4] ? (unit3 - 32'd1) : (unit_q - 32'd1);
        end
        S_TONE: begin
          if (!cnt_zero)            cnt_q <= cnt_q - 32'd1;
          else if (rem_q != 3'd0)   cnt_q <= unit_q - 32'd1;
          else                      cnt_q <= unit3 - 32'd1;
        end
        // The symbol register shifts left so the next symbol always sits at bit 3.
        S_SYM_GAP: begin
          if (!cnt_zero) cnt_q <= cnt_q - 32'd1;
          else begin
            rem_q <= rem_q - 3'd1;
            sym_q <= {sym_q[3:0], 1'b0};
            cnt_q <= sym_q[3] ? (unit3 - 32'd1) : (unit_q - 32'd1);
          end
        end
        S_SPACE: begin
          if (!cnt_zero) cnt_q <= cnt_q - 32'd1;
          else           cnt_q <= unit3 - 32'd1;
        end
        S_CHAR_GAP: begin
          if (!cnt_zero) cnt_q <= cnt_q - 32'd1;
          else           index_q <= index_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign beep      = (state_q == S_TONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_TONE) || (state_q == S_SYM_GAP) ||
                     (state_q == S_SPACE) || (state_q == S_CHAR_GAP);
  assign done      = (state_q == S_DONE);
  assign cur_index = busy ? index_q : 3'd0;

endmodule

// File: tb/tb_morse_playback_scheduler.sv
// Bench for morse_playback_scheduler: directed table, hand-written abort/reset sequences
// and randomized messages compared cycle by cycle against an expected output trace.
module tb_morse_playback_scheduler;

  localparam int UNIT = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [3:0]  char_count;
  logic [63:0] char_buf;
  logic [1:0]  speed_sel;
  logic        beep;
  logic        busy;
  logic        done;
  logic [2:0]  cur_index;

  morse_playback_scheduler #(.UNIT_CYCLES(UNIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .char_count (char_count),
    .char_buf   (char_buf),
    .speed_sel  (speed_sel),
    .beep       (beep),
    .busy       (busy),
    .done       (done),
    .cur_index  (cur_index)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one record per cycle, packed as {beep, busy, done, cur_index}
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int st_busy, st_high, st_done, st_max_idx;

  typedef struct {
    logic [63:0] b;
    logic [3:0]  c;
    logic [1:0]  s;
    int          busy_cyc;
    int          high_cyc;
    int          dones;
    int          max_idx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic b, input logic bz, input logic d, input int idx);
    exp_q.push_back({b, bz, d, 3'(idx)});
  endfunction

  // Reference: expand the message into its per-cycle output sequence from the timing rules.
  task automatic build_model(input logic [63:0] b, input logic [3:0] c, input logic [1:0] s);
    int n, u, len;
    logic [7:0] e;
    exp_q.delete();
    n = (c > 8) ? 8 : int'(c);
    u = UNIT * (int'(s) + 1);
    for (int i = 0; i < n; i++) begin
      e = b[i*8 +: 8];
      len = int'(e[7:5]);
      if (len > 5) len = 5;
      push_exp(0, 1, 0, i);
      if (len == 0) begin
        repeat (4*u) push_exp(0, 1, 0, i);
      end else begin
        for (int j = 0; j < len; j++) begin
          repeat (e[4-j] ? 3*u : u) push_exp(1, 1, 0, i);
          if (j < len - 1) repeat (u) push_exp(0, 1, 0, i);
        end
      end
      if (i < n - 1) repeat (3*u) push_exp(0, 1, 0, i);
    end
    push_exp(0, 0, 1, 0);
  endtask

  // Driver: call at a negedge with the DUT idle. Returns at a negedge with the DUT idle.
  task automatic play(input logic [63:0] b, input logic [3:0] c, input logic [1:0] s,
                      input bit perturb);
    logic [5:0] act;
    int n_exp;
    build_model(b, c, s);
    n_exp = exp_q.size();
    st_busy = 0; st_high = 0; st_done = 0; st_max_idx = 0;
    char_buf = b; char_count = c; speed_sel = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_exp; i++) begin
      if (i > 0) @(negedge clk);
      act = {beep, busy, done, cur_index};
      check($sformatf("trace[%0d]", i), 32'(act), 32'(exp_q[i]));
      st_busy += int'(busy);
      st_high += int'(beep);
      st_done += int'(done);
      if (int'(cur_index) > st_max_idx) st_max_idx = int'(cur_index);
      if (perturb && i < n_exp - 1) begin
        start      = 1'($urandom);
        char_buf   = {$urandom, $urandom};
        char_count = 4'($urandom);
        speed_sel  = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_after", 32'({beep, busy, done, cur_index}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    char_count = 4'd0; char_buf = 64'd0; speed_sel = 2'd0;

    // U=4 unless noted; E=0x20, T=0x30, A=0x48, space=0x00
    vecs[0] = '{64'h20,               4'd1,  2'd0, 5,   4,  1, 0};
    vecs[1] = '{64'h48,               4'd1,  2'd0, 21,  16, 1, 0};
    vecs[2] = '{64'h48,               4'd1,  2'd3, 81,  64, 1, 0};
    vecs[3] = '{64'h3020,             4'd2,  2'd0, 30,  16, 1, 1};
    vecs[4] = '{64'h200020,           4'd3,  2'd0, 51,  8,  1, 2};
    vecs[5] = '{64'h20,               4'd0,  2'd0, 0,   0,  1, 0};
    vecs[6] = '{64'h2020202020202020, 4'd12, 2'd0, 124, 32, 1, 7};

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({beep, busy, done, cur_index}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({beep, busy, done, cur_index}), 32'd0);

    for (int v = 0; v < 7; v++) begin
      play(vecs[v].b, vecs[v].c, vecs[v].s, 1'b0);
      check($sformatf("vec%0d_busy_cycles", v), 32'(st_busy), 32'(vecs[v].busy_cyc));
      check($sformatf("vec%0d_beep_cycles", v), 32'(st_high), 32'(vecs[v].high_cyc));
      check($sformatf("vec%0d_done_pulses", v), 32'(st_done), 32'(vecs[v].dones));
      check($sformatf("vec%0d_max_index", v), 32'(st_max_idx), 32'(vecs[v].max_idx));
    end

    // en dropped in the middle of T's dash: abort with no done, start held meanwhile
    char_buf = 64'h3020; char_count = 4'd2; speed_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("pre_abort_beep", 32'({beep, busy, cur_index}), 32'b1_1_001);
    en = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort[%0d]", i), 32'({beep, busy, done, cur_index}), 32'd0);
    end
    start = 1'b0;
    en = 1'b1;
    @(negedge clk);
    play(64'h3020, 4'd2, 2'd0, 1'b0);

    // Reset mid-playback behaves like an abort
    char_buf = 64'h48; char_count = 4'd1; speed_sel = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_abort", 32'({beep, busy, done, cur_index}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_abort_idle", 32'({beep, busy, done, cur_index}), 32'd0);

    // start spam and input edits while busy must leave the trace unchanged
    play(64'h0000_0000_0048_3020, 4'd3, 2'd0, 1'b1);

    for (int r = 0; r < 15; r++) begin
      play({$urandom, $urandom}, 4'($urandom_range(0, 12)), 2'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
